// File: rtl/axil_gpio_slave.sv
// AXI4-Lite responder for board I/O: LED register, two 7-segment nibbles, switch bank with change flags/irq.
// Latency: write response 2 cycles after simultaneous AW+W handshake; read data 1 cycle after AR handshake.
// Backpressure: one-entry AW/W holders (ready = holder empty); no commit while a write response is pending; arready = !rvalid.
module axil_gpio_slave #(
    parameter int          ADDR_W  = 8,
    parameter logic [7:0]  LED_RST = 8'h00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] s_awaddr,
    input  logic              s_awvalid,
    output logic              s_awready,
    input  logic [31:0]       s_wdata,
    input  logic [3:0]        s_wstrb,
    input  logic              s_wvalid,
    output logic              s_wready,
    output logic [1:0]        s_bresp,
    output logic              s_bvalid,
    input  logic              s_bready,
    input  logic [ADDR_W-1:0] s_araddr,
    input  logic              s_arvalid,
    output logic              s_arready,
    output logic [31:0]       s_rdata,
    output logic [1:0]        s_rresp,
    output logic              s_rvalid,
    input  logic              s_rready,
    input  logic [3:0]        sw_in,
    output logic [7:0]        led_out,
    output logic [3:0]        seg1_out,
    output logic [3:0]        seg2_out,
    output logic              irq
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Write holding registers (only the bits any register can use are kept)
    logic              aw_full;
    logic [ADDR_W-1:0] aw_addr;
    logic              w_full;
    logic [8:0]        w_data;
    logic [1:0]        w_strb;

    // Switch synchronizer, edge-detect copy, sticky change flags
    logic [3:0] sw_m;
    logic [3:0] sw_s;
    logic [3:0] sw_d;
    logic [3:0] flags;
    logic       irq_en;

    logic       aw_hs;
    logic       w_hs;
    logic       ar_hs;
    logic       commit;
    logic       wr_err;
    logic       led_we;
    logic       seg_we;
    logic       ien_we;
    logic [3:0] flag_clr;
    logic [31:0] rd_val;
    logic       rd_err;

    // Bits of the bus that no register decodes
    logic unused_bits;
    assign unused_bits = ^{s_wdata[31:9], s_wstrb[3:2], aw_addr[1:0], s_araddr[1:0]};

    assign s_awready = !aw_full;
    assign s_wready  = !w_full;
    assign s_arready = !s_rvalid;
    assign aw_hs     = s_awvalid && s_awready;
    assign w_hs      = s_wvalid && s_wready;
    assign ar_hs     = s_arvalid && s_arready;
    assign commit    = aw_full && w_full && !s_bvalid;

    // Write decode: which register lanes the committing beat updates
    always_comb begin
        wr_err   = 1'b0;
        led_we   = 1'b0;
        seg_we   = 1'b0;
        ien_we   = 1'b0;
        flag_clr = 4'h0;
        if ((aw_addr >> 4) != '0) begin
            wr_err = 1'b1;
        end else begin
            case (aw_addr[3:2])
                2'd0: led_we = commit && w_strb[0];
                2'd1: seg_we = commit && w_strb[0];
                2'd2: wr_err = 1'b1;
                default: begin
                    flag_clr = (commit && w_strb[0]) ? w_data[3:0] : 4'h0;
                    ien_we   = commit && w_strb[1];
                end
            endcase
        end
    end

    // AW/W holders fill on handshake and drain together on commit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_full <= 1'b0;
            aw_addr <= '0;
            w_full  <= 1'b0;
            w_data  <= '0;
            w_strb  <= '0;
        end else begin
            if (commit) begin
                aw_full <= 1'b0;
            end else if (aw_hs) begin
                aw_full <= 1'b1;
                aw_addr <= s_awaddr;
            end
            if (commit) begin
                w_full <= 1'b0;
            end else if (w_hs) begin
                w_full <= 1'b1;
                w_data <= s_wdata[8:0];
                w_strb <= s_wstrb[1:0];
            end
        end
    end

    // Write response: raised the cycle after commit, held until bready
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_bvalid <= 1'b0;
            s_bresp  <= RESP_OKAY;
        end else if (commit) begin
            s_bvalid <= 1'b1;
            s_bresp  <= wr_err ? RESP_SLVERR : RESP_OKAY;
        end else if (s_bvalid && s_bready) begin
            s_bvalid <= 1'b0;
        end
    end

    // Software-writable registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_out  <= LED_RST;
            seg1_out <= 4'h0;
            seg2_out <= 4'h0;
            irq_en   <= 1'b0;
        end else begin
            if (led_we) begin
                led_out <= w_data[7:0];
            end
            if (seg_we) begin
                seg1_out <= w_data[3:0];
                seg2_out <= w_data[7:4];
            end
            if (ien_we) begin
                irq_en <= w_data[8];
            end
        end
    end

    // Switch sync, change flags (a new edge beats a same-cycle W1C) and registered irq
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_m  <= 4'h0;
            sw_s  <= 4'h0;
            sw_d  <= 4'h0;
            flags <= 4'h0;
            irq   <= 1'b0;
        end else begin
            sw_m  <= sw_in;
            sw_s  <= sw_m;
            sw_d  <= sw_s;
            flags <= (flags & ~flag_clr) | (sw_s ^ sw_d);
            irq   <= irq_en && (|flags);
        end
    end

    // Read mux over current register state
    always_comb begin
        rd_val = 32'h0;
        rd_err = 1'b0;
        if ((s_araddr >> 4) != '0) begin
            rd_err = 1'b1;
        end else begin
            case (s_araddr[3:2])
                2'd0:    rd_val = {24'h0, led_out};
                2'd1:    rd_val = {24'h0, seg2_out, seg1_out};
                2'd2:    rd_val = {28'h0, sw_s};
                default: rd_val = {23'h0, irq_en, 4'h0, flags};
            endcase
        end
    end

    // Read response: captured on AR handshake, held until rready
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_rvalid <= 1'b0;
            s_rdata  <= 32'h0;
            s_rresp  <= RESP_OKAY;
        end else if (ar_hs) begin
            s_rvalid <= 1'b1;
            s_rdata  <= rd_val;
            s_rresp  <= rd_err ? RESP_SLVERR : RESP_OKAY;
        end else if (s_rvalid && s_rready) begin
            s_rvalid <= 1'b0;
        end
    end

endmodule
